mem_access_unit: RTL



---
 rtl/mem_access_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a 1K x32 data memory: extends sub-word loads,
// performs sub-word stores as read-modify-write and rejects misaligned requests.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Req,
  input  logic [2:0]        Op,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] StoreData,
  output logic              Busy,
  output logic              Done,
  output logic              Misaligned,
  output logic [DATA_W-1:0] LoadData,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] MemReadData
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WSTORE, RESP} state_t;

  state_t            state;
  state_t            state_next;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] merge_q;
  logic              mis_q;
  logic [DATA_W-1:0] load_q;
  logic              accept;
  logic              req_mis;
  logic              mem_active;
  logic [4:0]        lane_sh;
  logic [DATA_W-1:0] lane_rd;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] merged;

  // Handshake: Req is sampled at a rising edge only while Busy=0 (IDLE); a request
  // presented while Busy=1 is dropped and must be re-presented. Completion is a
  // single-cycle Done, with Misaligned qualifying it in the same cycle.
  assign accept = (state == IDLE) && Req;

  always_comb begin
    req_mis = 1'b0;
    case (Op)
      OP_LW, OP_SW:         req_mis = (Addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: req_mis = Addr[0];
      default:              req_mis = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (Req) begin
          if (req_mis)                       state_next = RESP;
          else if (Op == OP_SW)              state_next = WSTORE;
          else if (Op == OP_SH || Op == OP_SB) state_next = RMW_RD;
          else                               state_next = LOAD;
        end
      end
      LOAD:    state_next = RESP;
      RMW_RD:  state_next = WSTORE;
      WSTORE:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Byte and halfword lanes are both selected by shifting the word down by Addr[1:0] bytes.
  assign lane_sh = {addr_q[1:0], 3'b000};
  assign lane_rd = MemReadData >> lane_sh;

  always_comb begin
    load_ext = MemReadData;
    case (op_q)
      OP_LH:   load_ext = {{16{lane_rd[15]}}, lane_rd[15:0]};
      OP_LHU:  load_ext = {16'h0000, lane_rd[15:0]};
      OP_LB:   load_ext = {{24{lane_rd[7]}}, lane_rd[7:0]};
      OP_LBU:  load_ext = {24'h000000, lane_rd[7:0]};
      default: load_ext = MemReadData;
    endcase
  end

  assign lane_mask = ((op_q == OP_SB) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_sh;
  assign merged    = (MemReadData & ~lane_mask) | ((merge_q << lane_sh) & lane_mask);

  // merge_q first holds the raw store data, then the merged word for sub-word stores.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      op_q    <= '0;
      addr_q  <= '0;
      merge_q <= '0;
      mis_q   <= 1'b0;
      load_q  <= '0;
    end else begin
      if (accept) begin
        op_q    <= Op;
        addr_q  <= Addr;
        merge_q <= StoreData;
        mis_q   <= req_mis;
      end
      if (state == LOAD)   load_q  <= load_ext;
      if (state == RMW_RD) merge_q <= merged;
    end
  end

  assign mem_active   = (state == LOAD) || (state == RMW_RD) || (state == WSTORE);
  assign Busy         = (state != IDLE);
  assign Done         = (state == RESP);
  assign Misaligned   = (state == RESP) && mis_q;
  assign LoadData     = load_q;
  assign MemAddress   = mem_active ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign MemRead      = (state == LOAD) || (state == RMW_RD);
  assign MemWrite     = (state == WSTORE);
  assign MemWriteData = (state == WSTORE) ? merge_q : '0;

endmodule
